// File: rtl/sc_matrix_tx_if.sv
// Screen-source handshake and MAX7219 serial pins for sc_matrix_tx.
interface sc_matrix_tx_if;
  logic       SC_MATRIXTX_start_In;
  logic [7:0] SC_MATRIXTX_rowData_InBUS;
  logic [2:0] SC_MATRIXTX_rowSel_OutBUS;
  logic       SC_MATRIXTX_busy_Out;
  logic       SC_MATRIXTX_done_Out;
  logic       SC_MATRIXTX_din_Out;
  logic       SC_MATRIXTX_sclk_Out;
  logic       SC_MATRIXTX_load_Out;

  modport master (
    output SC_MATRIXTX_start_In,
    output SC_MATRIXTX_rowData_InBUS,
    input  SC_MATRIXTX_rowSel_OutBUS,
    input  SC_MATRIXTX_busy_Out,
    input  SC_MATRIXTX_done_Out,
    input  SC_MATRIXTX_din_Out,
    input  SC_MATRIXTX_sclk_Out,
    input  SC_MATRIXTX_load_Out
  );

  modport slave (
    input  SC_MATRIXTX_start_In,
    input  SC_MATRIXTX_rowData_InBUS,
    output SC_MATRIXTX_rowSel_OutBUS,
    output SC_MATRIXTX_busy_Out,
    output SC_MATRIXTX_done_Out,
    output SC_MATRIXTX_din_Out,
    output SC_MATRIXTX_sclk_Out,
    output SC_MATRIXTX_load_Out
  );
endinterface

// File: rtl/sc_matrix_tx.sv
// MAX7219 8x8 matrix transmitter: init sequence, then 8-row refresh on start.
// Define SC_MATRIXTX_DISPLAYTEST_EN to send display-test-on as first init frame.
module sc_matrix_tx #(
  parameter int         CLKDIV    = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input logic           SC_MATRIXTX_CLOCK_50,
  input logic           SC_MATRIXTX_RESET_InHigh,
  sc_matrix_tx_if.slave bus
);

  typedef enum logic [2:0] {
    INIT_LOAD,
    IDLE,
    ROW_REQ,
    ROW_LOAD,
    SHIFT,
    LATCH
  } state_t;

  localparam logic [7:0] HALF_MAX = 8'(CLKDIV - 1);
`ifdef SC_MATRIXTX_DISPLAYTEST_EN
  localparam logic [15:0] TEST_FRAME = 16'h0F01;
`else
  localparam logic [15:0] TEST_FRAME = 16'h0F00;
`endif

  logic        clk;
  logic        rst;
  state_t      state;
  state_t      state_n;
  logic [2:0]  init_idx;
  logic [2:0]  row;
  logic        refresh;
  logic [15:0] shreg;
  logic [3:0]  bit_cnt;
  logic [7:0]  half_cnt;
  logic        phase;
  logic        half_end;
  logic        bit_last;
  logic        done;
  logic [3:0]  row_addr;

  assign clk      = SC_MATRIXTX_CLOCK_50;
  assign rst      = SC_MATRIXTX_RESET_InHigh;
  assign half_end = (half_cnt == HALF_MAX);
  assign bit_last = (bit_cnt == 4'd15);
  assign row_addr = {1'b0, row} + 4'd1;

  function automatic logic [15:0] init_frame(input logic [2:0] idx);
    case (idx)
      3'd0:    init_frame = TEST_FRAME;
      3'd1:    init_frame = 16'h0900;
      3'd2:    init_frame = {12'h0A0, INTENSITY};
      3'd3:    init_frame = 16'h0B07;
      default: init_frame = 16'h0C01;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    done    = 1'b0;
    unique case (state)
      INIT_LOAD: state_n = SHIFT;
      IDLE:      if (bus.SC_MATRIXTX_start_In) state_n = ROW_REQ;
      ROW_REQ:   state_n = ROW_LOAD;
      ROW_LOAD:  state_n = SHIFT;
      SHIFT:     if (phase && half_end && bit_last) state_n = LATCH;
      LATCH: begin
        if (phase && half_end) begin
          if (!refresh) begin
            state_n = (init_idx == 3'd5) ? IDLE : SHIFT;
          end else if (row == 3'd7) begin
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            state_n = ROW_REQ;
          end
        end
      end
      default:   state_n = INIT_LOAD;
    endcase
  end

  // done fires in the last gap cycle, so busy drops with it before IDLE
  assign bus.SC_MATRIXTX_busy_Out      = (state != IDLE) && !done;
  assign bus.SC_MATRIXTX_done_Out      = done;
  assign bus.SC_MATRIXTX_load_Out      = (state != SHIFT);
  assign bus.SC_MATRIXTX_sclk_Out      = (state == SHIFT) && phase;
  assign bus.SC_MATRIXTX_din_Out       = (state == SHIFT) && shreg[15];
  assign bus.SC_MATRIXTX_rowSel_OutBUS = row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT_LOAD;
      init_idx <= '0;
      row      <= '0;
      refresh  <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      half_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        INIT_LOAD: begin
          shreg    <= init_frame(init_idx);
          init_idx <= init_idx + 3'd1;
          bit_cnt  <= '0;
          half_cnt <= '0;
          phase    <= 1'b0;
        end
        IDLE: begin
          if (bus.SC_MATRIXTX_start_In) begin
            refresh <= 1'b1;
            row     <= '0;
          end
        end
        ROW_LOAD: begin
          shreg    <= {4'h0, row_addr, bus.SC_MATRIXTX_rowData_InBUS};
          bit_cnt  <= '0;
          half_cnt <= '0;
          phase    <= 1'b0;
        end
        SHIFT: begin
          if (half_end) begin
            half_cnt <= '0;
            phase    <= ~phase;
            if (phase && !bit_last) begin
              bit_cnt <= bit_cnt + 4'd1;
              shreg   <= {shreg[14:0], 1'b0};
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        LATCH: begin
          if (half_end) begin
            half_cnt <= '0;
            phase    <= ~phase;
            if (phase) begin
              bit_cnt <= '0;
              if (!refresh) begin
                if (init_idx != 3'd5) begin
                  shreg    <= init_frame(init_idx);
                  init_idx <= init_idx + 3'd1;
                end
              end else if (row == 3'd7) begin
                refresh <= 1'b0;
              end else begin
                row <= row + 3'd1;
              end
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_matrix_tx.sv
// Self-checking bench for sc_matrix_tx: decodes the serial stream into frames.
module tb_sc_matrix_tx;
  localparam int CLKDIV = 2;
  localparam int FLOW   = 32 * CLKDIV;
  localparam int GAP    = 2 * CLKDIV;
`ifdef SC_MATRIXTX_DISPLAYTEST_EN
  localparam logic [15:0] FIRST = 16'h0F01;
`else
  localparam logic [15:0] FIRST = 16'h0F00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  sc_matrix_tx_if bus ();

  sc_matrix_tx #(
    .CLKDIV   (CLKDIV),
    .INTENSITY(4'h8)
  ) dut (
    .SC_MATRIXTX_CLOCK_50    (clk),
    .SC_MATRIXTX_RESET_InHigh(rst),
    .bus                     (bus)
  );

  always #5 clk = ~clk;

  wire       m_load = bus.SC_MATRIXTX_load_Out;
  wire       m_sclk = bus.SC_MATRIXTX_sclk_Out;
  wire       m_din  = bus.SC_MATRIXTX_din_Out;
  wire       m_busy = bus.SC_MATRIXTX_busy_Out;
  wire       m_done = bus.SC_MATRIXTX_done_Out;
  wire [2:0] m_sel  = bus.SC_MATRIXTX_rowSel_OutBUS;

  logic [15:0] init_exp [5] = '{FIRST, 16'h0900, 16'h0A08, 16'h0B07, 16'h0C01};

  int errors = 0;
  int checks = 0;

  logic [7:0] rows [8];
  bit         toggle_mode = 1'b0;

  // Screen source: row table, or noise while a frame is on the wire.
  always @(negedge clk) begin
    if (toggle_mode && m_load === 1'b0)
      bus.SC_MATRIXTX_rowData_InBUS = 8'($urandom);
    else
      bus.SC_MATRIXTX_rowData_InBUS = rows[m_sel];
  end

  // Serial receiver model: one sample per cycle, away from the rising edge.
  logic [15:0] fq [$];
  int          lq [$];
  int          bq [$];
  int          gq [$];
  logic [15:0] sh = '0;
  int          nbits = 0, lowc = 0, gapc = 0;
  int          done_cnt = 0, done_busy_bad = 0, din_bad = 0;
  logic        pl = 1'b1, ps = 1'b0, pd = 1'b0;

  always @(negedge clk) begin
    if (m_load === 1'b0) begin
      if (pl === 1'b1) begin
        gq.push_back(gapc);
        nbits = 0;
        lowc  = 0;
        sh    = '0;
      end
      lowc++;
      if (m_sclk === 1'b1 && ps !== 1'b1) begin
        sh = {sh[14:0], m_din};
        nbits++;
      end
      if (m_sclk === 1'b1 && ps === 1'b1 && m_din !== pd) din_bad++;
    end else begin
      if (pl === 1'b0) begin
        fq.push_back(sh);
        lq.push_back(lowc);
        bq.push_back(nbits);
        gapc = 0;
      end
      gapc++;
    end
    if (m_done === 1'b1) begin
      done_cnt++;
      if (m_busy !== 1'b0) done_busy_bad++;
    end
    pl = m_load;
    ps = m_sclk;
    pd = m_din;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      cyc(1);
      if (m_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    bus.SC_MATRIXTX_start_In = 1'b1;
    cyc(1);
    bus.SC_MATRIXTX_start_In = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    checks++;
    if (m_load !== 1'b1) begin
      errors++; $display("FAIL reset_load: got %b want 1", m_load);
    end
    checks++;
    if (m_sclk !== 1'b0) begin
      errors++; $display("FAIL reset_sclk: got %b want 0", m_sclk);
    end
    checks++;
    if (m_din !== 1'b0) begin
      errors++; $display("FAIL reset_din: got %b want 0", m_din);
    end
    checks++;
    if (m_busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b want 1", m_busy);
    end
    checks++;
    if (m_done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", m_done);
    end
    checks++;
    if (m_sel !== 3'd0) begin
      errors++; $display("FAIL reset_rowsel: got %0d want 0", m_sel);
    end
  endtask

  task automatic test_init();
    int fb = fq.size();
    int gb = gq.size();
    int db = done_cnt;
    bit ok;
    rst = 1'b0;
    wait_idle(2000, ok);
    cyc(3);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL init_timeout: busy still high after 2000 cycles");
    end
    checks++;
    if (fq.size() - fb !== 5) begin
      errors++; $display("FAIL init_count: got %0d frames want 5", fq.size() - fb);
    end
    for (int i = 0; i < 5 && fb + i < fq.size(); i++) begin
      checks++;
      if (fq[fb+i] !== init_exp[i]) begin
        errors++; $display("FAIL init_frame%0d: got %h want %h", i, fq[fb+i], init_exp[i]);
      end
      checks++;
      if (lq[fb+i] !== FLOW || bq[fb+i] !== 16) begin
        errors++;
        $display("FAIL init_len%0d: got %0d clk/%0d bits want %0d/16", i, lq[fb+i], bq[fb+i], FLOW);
      end
    end
    for (int i = 1; i < 5 && gb + i < gq.size(); i++) begin
      checks++;
      if (gq[gb+i] !== GAP) begin
        errors++; $display("FAIL init_gap%0d: got %0d want %0d", i, gq[gb+i], GAP);
      end
    end
    checks++;
    if (done_cnt - db !== 0) begin
      errors++; $display("FAIL init_done: got %0d pulses want 0", done_cnt - db);
    end
  endtask

  task automatic check_refresh(input string name, input int fb, input int gb, input int db);
    checks++;
    if (fq.size() - fb !== 8) begin
      errors++; $display("FAIL %s_count: got %0d frames want 8", name, fq.size() - fb);
    end
    for (int n = 0; n < 8 && fb + n < fq.size(); n++) begin
      logic [15:0] exp;
      exp = 16'((n + 1) * 256 + int'(rows[n]));
      checks++;
      if (fq[fb+n] !== exp) begin
        errors++; $display("FAIL %s_row%0d: got %h want %h", name, n, fq[fb+n], exp);
      end
      checks++;
      if (lq[fb+n] !== FLOW || bq[fb+n] !== 16) begin
        errors++;
        $display("FAIL %s_len%0d: got %0d clk/%0d bits want %0d/16", name, n, lq[fb+n], bq[fb+n], FLOW);
      end
      if (n > 0 && gb + n < gq.size()) begin
        checks++;
        if (gq[gb+n] < GAP) begin
          errors++; $display("FAIL %s_gap%0d: got %0d want >= %0d", name, n, gq[gb+n], GAP);
        end
      end
    end
    checks++;
    if (done_cnt - db !== 1) begin
      errors++; $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt - db);
    end
    checks++;
    if (done_busy_bad !== 0) begin
      errors++; $display("FAIL %s_done_busy: got %0d busy-high done cycles want 0", name, done_busy_bad);
    end
    checks++;
    if (din_bad !== 0) begin
      errors++; $display("FAIL %s_din_stable: got %0d changes while sclk high want 0", name, din_bad);
    end
  endtask

  task automatic test_refresh(input string name, input bit rnd);
    int fb, gb, db;
    bit ok;
    for (int n = 0; n < 8; n++) rows[n] = rnd ? 8'($urandom) : 8'(1 << n);
    cyc(2);
    fb = fq.size(); gb = gq.size(); db = done_cnt;
    pulse_start();
    checks++;
    if (m_busy !== 1'b1 || m_sel !== 3'd0) begin
      errors++; $display("FAIL %s_accept: got busy=%b sel=%0d want busy=1 sel=0", name, m_busy, m_sel);
    end
    wait_idle(2000, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL %s_timeout: busy still high after 2000 cycles", name);
    end
    cyc(3);
    check_refresh(name, fb, gb, db);
  endtask

  task automatic test_back_to_back();
    int fb, gb, db, fz;
    bit ok;
    for (int n = 0; n < 8; n++) rows[n] = 8'($urandom);
    fb = fq.size(); gb = gq.size(); db = done_cnt;
    pulse_start();
    cyc(9);
    pulse_start();
    cyc(189);
    pulse_start();
    wait_idle(2000, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL b2b_timeout: busy still high after 2000 cycles");
    end
    cyc(3);
    check_refresh("b2b", fb, gb, db);
    fz = fq.size();
    cyc(200);
    checks++;
    if (fq.size() !== fz || m_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_not_queued: got %0d extra frames busy=%b want 0/0", fq.size() - fz, m_busy);
    end
  endtask

  task automatic test_toggle();
    int fb, gb, db;
    bit ok;
    for (int n = 0; n < 8; n++) rows[n] = 8'($urandom);
    fb = fq.size(); gb = gq.size(); db = done_cnt;
    toggle_mode = 1'b1;
    pulse_start();
    wait_idle(2000, ok);
    toggle_mode = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL toggle_timeout: busy still high after 2000 cycles");
    end
    cyc(3);
    check_refresh("toggle", fb, gb, db);
  endtask

  task automatic test_reset_mid();
    int fb, db;
    bit ok, found;
    for (int n = 0; n < 8; n++) rows[n] = 8'(1 << n);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cyc(1);
      if (m_sel === 3'd3 && m_load === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL rmid_reach_row3: row 3 frame never started");
    end
    cyc(20);
    rst = 1'b1;
    cyc(1);
    checks++;
    if (m_load !== 1'b1 || m_sclk !== 1'b0 || m_busy !== 1'b1 || m_sel !== 3'd0) begin
      errors++;
      $display("FAIL rmid_abort: got load=%b sclk=%b busy=%b sel=%0d want 1/0/1/0", m_load, m_sclk, m_busy, m_sel);
    end
    rst = 1'b0;
    cyc(1);
    fb = fq.size(); db = done_cnt;
    wait_idle(2000, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL rmid_timeout: busy still high after 2000 cycles");
    end
    cyc(3);
    checks++;
    if (fq.size() - fb !== 5) begin
      errors++; $display("FAIL rmid_count: got %0d frames want 5", fq.size() - fb);
    end
    for (int i = 0; i < 5 && fb + i < fq.size(); i++) begin
      checks++;
      if (fq[fb+i] !== init_exp[i]) begin
        errors++; $display("FAIL rmid_frame%0d: got %h want %h", i, fq[fb+i], init_exp[i]);
      end
    end
    checks++;
    if (done_cnt - db !== 0) begin
      errors++; $display("FAIL rmid_done: got %0d pulses want 0", done_cnt - db);
    end
  endtask

  initial begin
    bus.SC_MATRIXTX_start_In = 1'b0;
    for (int n = 0; n < 8; n++) rows[n] = '0;
    test_reset();
    test_init();
    test_refresh("pattern", 1'b0);
    test_refresh("random_a", 1'b1);
    test_refresh("random_b", 1'b1);
    test_back_to_back();
    test_toggle();
    test_reset_mid();
    test_refresh("after_reset", 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
